// File: rtl/rom_fetch_adapter.sv
// rtl/rom_fetch_adapter.sv - host fetch front end for the boot ROM
// One-deep ROM pipe feeding a 3-entry in-order response FIFO; illegal requests bypass the ROM.
module rom_fetch_adapter #(
  parameter int Width = 32,
  parameter int Depth = 2048,
  parameter int Aw    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_addr_i,
  input  logic             req_we_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [Width-1:0] rsp_rdata_o,
  output logic             rsp_err_o,
  output logic             rom_cs_o,
  output logic [Aw-1:0]    rom_addr_o,
  input  logic [Width-1:0] rom_rdata_i,
  input  logic             rom_dvalid_i,
  output logic             alert_o
);

  localparam logic [29:0] DepthW = 30'(Depth);

  logic [Width:0] mem_q [3];
  logic [1:0]     wr_ptr_q, rd_ptr_q, count_q, count_d;
  logic           pipe_v_q, pipe_err_q, alert_q;
  logic           acc, err, push, pop, dv_exp;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Full 30-bit word index compared against Depth so high address bits cannot alias.
  assign err = req_we_i | (req_addr_i[1:0] != 2'b00) | (req_addr_i[31:2] >= DepthW);
  assign acc = req_valid_i & req_ready_o;

  assign rom_cs_o   = acc & ~err;
  assign rom_addr_o = req_addr_i[Aw+1:2];

  // Credit counts the in-flight pipe slot so a capture always finds room.
  assign req_ready_o = ({1'b0, count_q} + {2'b00, pipe_v_q}) < 3'd3;

  assign push        = pipe_v_q;
  assign rsp_valid_o = (count_q != 2'd0);
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign rsp_rdata_o = mem_q[rd_ptr_q][Width:1];
  assign rsp_err_o   = mem_q[rd_ptr_q][0];

  assign dv_exp  = pipe_v_q & ~pipe_err_q;
  assign alert_o = alert_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_v_q   <= 1'b0;
      pipe_err_q <= 1'b0;
      alert_q    <= 1'b0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 2'd0;
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
    end else begin
      pipe_v_q   <= acc;
      pipe_err_q <= err;
      count_q    <= count_d;
      alert_q    <= alert_q | (rom_dvalid_i != dv_exp);
      if (push) begin
        mem_q[wr_ptr_q] <= {(pipe_err_q ? {Width{1'b0}} : rom_rdata_i), pipe_err_q};
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

endmodule

// File: doc/rom_fetch_adapter.md
# rom_fetch_adapter

Request/response front end that sits directly upstream of the boot ROM primitive. It accepts word reads from a host fetch port with valid/ready handshakes, drives the ROM's chip-select and word address, and captures ROM data on the ROM's data-valid strobe. It returns in-order responses through a 3-entry response buffer. Illegal requests (writes, misaligned, out of range) are answered with an error and never reach the ROM.

## Interface
- `Width`, 32: ROM word width; also the width of `rsp_rdata_o`.
- `Depth`, 2048: ROM depth in words.
- `Aw`, `$clog2(Depth)`: ROM word-address width.
- `clk_i`  in  1  clock; every register is clocked on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  host request valid.
- `req_ready_o`  out  1  request accepted when valid and ready are both high.
- `req_addr_i`  in  32  byte address, offset from the ROM base.
- `req_we_i`  in  1  write request; always illegal.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  host takes the response.
- `rsp_rdata_o`  out  Width  read data; 0 on error.
- `rsp_err_o`  out  1  error response.
- `rom_cs_o`  out  1  ROM chip select.
- `rom_addr_o`  out  Aw  ROM word address.
- `rom_rdata_i`  in  Width  ROM data output.
- `rom_dvalid_i`  in  1  ROM data valid; ROM latency is fixed at 1 cycle.
- `alert_o`  out  1  sticky ROM handshake integrity fault.

## Operation
- **Accept:** `acc = req_valid_i & req_ready_o`.
- **Error check:** `err = req_we_i | (req_addr_i[1:0] != 0) | (req_addr_i[31:2] >= Depth)`. The range compare is done at full 30-bit width; no truncation before the compare.
- **ROM drive (combinational):**
  - `rom_cs_o = acc & ~err`.
  - `rom_addr_o = req_addr_i[Aw+1:2]`, driven regardless of validity.
- **Pipe stage:**
  - Registers `pipe_v <= acc` and `pipe_err <= err`.
  - Exactly one request can be in flight between accept and capture.
- **Capture:** when `pipe_v` is high, push `{pipe_err ? 0 : rom_rdata_i, pipe_err}` into the response FIFO. Error requests occupy a pipe slot like good ones, so order is preserved.
- **Response FIFO:**
  - 3 entries, circular, with 2-bit read and write pointers and a 0..3 count.
  - Head drives `rsp_rdata_o` and `rsp_err_o`. `rsp_valid_o = (count != 0)`.
  - Pop when `rsp_valid_o & rsp_ready_i`.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap 2 -> 0.
- **Credit:**
  - `req_ready_o = (count + pipe_v) < 3`, computed from registers only, with no combinational path from `rsp_ready_i`.
  - This guarantees a push never finds the FIFO full. An overflow is a design error; the bench asserts that it never happens.
- **Integrity:**
  - Expected strobe: `exp = pipe_v & ~pipe_err`.
  - If `rom_dvalid_i != exp` in any cycle, `alert_o` sets.
  - `alert_o` stays set until reset. Data flow is unaffected; capture uses `pipe_v`, not `rom_dvalid_i`.

## Timing
- **Reset values:**
  - `req_ready_o = 1`, `rsp_valid_o = 0`, `rsp_rdata_o = 0`, `rsp_err_o = 0`, `rom_cs_o = 0`, `alert_o = 0`.
  - FIFO empty, `pipe_v = 0`.
- **Latency:**
  - Accept in cycle N -> ROM samples the address at the end of N -> data and dvalid in N+1 -> FIFO write at the end of N+1.
  - `rsp_valid_o` is high in N+2, for good and error requests alike.
- **Throughput:** one request per cycle sustained while the host pops every cycle. Steady state is `count = 1`, `pipe_v = 1`, ready high.
- **Back-pressure:** with `rsp_ready_i = 0`, at most 3 requests are accepted. Ready drops once `count + pipe_v = 3`.
- **Ready recovery:** ready returns the cycle after the first pop.
- **Response stability:** a response held under back-pressure keeps valid and data stable until taken.
- **Reset mid-operation:** asynchronous assertion clears the pipe, FIFO and alert immediately, and `rom_cs_o` drops in the same cycle. In-flight ROM data is discarded and no stale response appears after release.

## Test plan
- **Reset:** reset, then read addresses 0x0, 0x4, 0x1FFC back to back with `rsp_ready_i = 1`.
  - `rom_addr_o` = 0, 1, 0x7FF on consecutive cycles.
  - Responses return memory words 0, 1, 2047 in order, each 2 cycles after accept, one per cycle.
- **Errors:** issue a write to 0x10, a read of 0x6, and a read of 0x2000, interleaved with a good read of 0x8.
  - `rom_cs_o` is high only for 0x8.
  - Responses in order: err/0, err/0, err/0 and `mem[2]`, each in its issued position.
- **Back-pressure:** hold `rsp_ready_i = 0` and stream 5 requests.
  - Exactly 3 are accepted; `req_ready_o` is 0 from the cycle after the third accept.
  - Release `rsp_ready_i`: all 5 complete in order, and count wraps through pointer 2 -> 0.
- **Integrity:** force `rom_dvalid_i` to 0 in the cycle after a good accept.
  - `alert_o` = 1 the next cycle and stays 1.
  - Data is still returned. Only reset clears the alert.
- **Reset mid-operation:** accept 2 requests, then assert `rst_ni` low for 1 cycle between the accept and the capture.
  - Outputs return to reset values immediately.
  - `rsp_valid_o` stays 0 after release until new requests arrive.
- **Random stress:** random valid/ready with a ROM model of latency 1, over 10k cycles.
  - Scoreboard compares order and data.
  - No FIFO overflow, and `alert_o` never sets.
